// File: rtl/divider_shift_sub_signed_pkg.sv
// Shared types and sizing helpers for the signed shift-subtract divider.
package div_pkg;

  localparam int unsigned N_DEFAULT = 6;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  // Counter must hold 0..2N.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/divider_shift_sub_signed_if.sv
// Start/busy/done request and result bundle for the signed divider.
interface divider_shift_sub_signed_if #(
  parameter int unsigned N = div_pkg::N_DEFAULT
);
  logic                  start;
  logic signed [2*N-1:0] dividend;
  logic signed [N-1:0]   divisor;
  logic                  busy;
  logic                  done;
  logic signed [2*N-1:0] quotient;
  logic signed [N-1:0]   remainder;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/divider_shift_sub_signed_abs_conv.sv
// Conditional two's-complement negate: magnitude when neg_i is the sign, restore otherwise.
module abs_conv #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);
  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/divider_shift_sub_signed.sv
// Sequential signed restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per cycle.
module divider_shift_sub_signed
  import div_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input logic                        clk,
  input logic                        rst,
  divider_shift_sub_signed_if.slave  bus
);
  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = cnt_width(N);

  state_t          state_q;
  logic [W-1:0]    dividend_q;
  logic [N-1:0]    divisor_q;
  logic [W-1:0]    dq_q;        // |dividend| shifting out, quotient bits shifting in
  logic [N-1:0]    dvs_mag_q;
  logic [N:0]      prem_q;
  logic [CW-1:0]   cnt_q;
  logic            q_sign_q;
  logic            r_sign_q;

  logic            fix_sel;
  logic [W-1:0]    wide_res;
  logic [N-1:0]    narrow_res;
  logic [N+1:0]    shifted;
  logic [N+1:0]    diff;
  logic            is_ovf;

  // One converter pair serves PREP (magnitudes) and FIX (sign restore).
  assign fix_sel = (state_q == FIX);

  abs_conv #(.W(W)) u_abs_wide (
    .val_i (fix_sel ? dq_q : dividend_q),
    .neg_i (fix_sel ? q_sign_q : dividend_q[W-1]),
    .res_o (wide_res)
  );

  abs_conv #(.W(N)) u_abs_narrow (
    .val_i (fix_sel ? prem_q[N-1:0] : divisor_q),
    .neg_i (fix_sel ? r_sign_q : divisor_q[N-1]),
    .res_o (narrow_res)
  );

  always_comb begin
    shifted = {prem_q, dq_q[W-1]};
    diff    = shifted - {2'b00, dvs_mag_q};
    is_ovf  = (dividend_q == {1'b1, {(W-1){1'b0}}}) && (divisor_q == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      dividend_q      <= '0;
      divisor_q       <= '0;
      dq_q            <= '0;
      dvs_mag_q       <= '0;
      prem_q          <= '0;
      cnt_q           <= '0;
      q_sign_q        <= 1'b0;
      r_sign_q        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            dividend_q      <= bus.dividend;
            divisor_q       <= bus.divisor;
            bus.busy        <= 1'b1;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
            if (bus.divisor == '0) begin
              bus.quotient    <= '0;
              bus.remainder   <= '0;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
              state_q         <= DONE;
            end else begin
              state_q <= PREP;
            end
          end
        end
        PREP: begin
          dq_q      <= wide_res;
          dvs_mag_q <= narrow_res;
          q_sign_q  <= dividend_q[W-1] ^ divisor_q[N-1];
          r_sign_q  <= dividend_q[W-1];
          prem_q    <= '0;
          cnt_q     <= '0;
          state_q   <= CALC;
        end
        CALC: begin
          // Negative trial result restores the shifted remainder.
          prem_q <= diff[N+1] ? shifted[N:0] : diff[N:0];
          dq_q   <= {dq_q[W-2:0], ~diff[N+1]};
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_q <= FIX;
        end
        FIX: begin
          bus.quotient  <= wide_res;
          bus.remainder <= narrow_res;
          bus.overflow  <= is_ovf;
          bus.done      <= 1'b1;
          state_q       <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
